// File: rtl/mem_req_arbiter.sv
// Arbiter for the memory adapter's single task port: store > load > fetch with
// a fetch anti-starvation boost, plus flush squashing. Optional counters: MEM_ARB_STATS_EN.
module mem_req_arbiter #(
  parameter int AGE_LIMIT = 4,
  parameter int AGE_W     = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic        mem_task,
  output logic [31:0] mem_addr,
  output logic        mem_rw,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_wdata,
  input  logic        mem_task_done,
  input  logic [31:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_if_cnt,
  output logic [31:0] stat_ld_cnt,
  output logic [31:0] stat_st_cnt,
  output logic [31:0] stat_squash_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic [1:0] {W_IF, W_LD, W_ST} winner_t;

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  state_t      state_q, state_d;
  winner_t     winner_q, winner_d;
  logic        mem_task_q, mem_task_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_rw_q, mem_rw_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_done_q, if_done_d;
  logic        ld_done_q, ld_done_d;
  logic        st_done_q, st_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic        squash_q, squash_d;

  logic if_eff, ld_eff, fetch_boost;
  logic grant_if, grant_ld, grant_st;
  logic squash_now, suppress_done;

  // Flush in IDLE masks the speculative requesters for that cycle only.
  assign if_eff      = if_req & ~flush_pipline;
  assign ld_eff      = ld_req & ~flush_pipline;
  assign fetch_boost = if_eff && (age_q == AGE_MAX);

  always_comb begin
    grant_if = 1'b0;
    grant_ld = 1'b0;
    grant_st = 1'b0;
    if (state_q == S_IDLE) begin
      if (fetch_boost)  grant_if = 1'b1;
      else if (st_req)  grant_st = 1'b1;
      else if (ld_eff)  grant_ld = 1'b1;
      else if (if_eff)  grant_if = 1'b1;
    end
  end

  assign squash_now    = flush_pipline && (winner_q != W_ST);
  assign suppress_done = (state_q == S_BUSY) && mem_task_done && (squash_q || squash_now);

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    mem_task_d  = mem_task_q;
    mem_addr_d  = mem_addr_q;
    mem_rw_d    = mem_rw_q;
    mem_size_d  = mem_size_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    ld_done_d   = 1'b0;
    st_done_d   = 1'b0;
    if_data_d   = if_data_q;
    ld_data_d   = ld_data_q;
    age_d       = age_q;
    squash_d    = squash_q;

    case (state_q)
      S_IDLE: begin
        squash_d = 1'b0;
        if (grant_if) begin
          winner_d   = W_IF;
          mem_addr_d = if_addr;
          mem_rw_d   = 1'b0;
          mem_size_d = 2'b10;
        end else if (grant_st) begin
          winner_d    = W_ST;
          mem_addr_d  = st_addr;
          mem_rw_d    = 1'b1;
          mem_size_d  = st_size;
          mem_wdata_d = st_data;
        end else if (grant_ld) begin
          winner_d   = W_LD;
          mem_addr_d = ld_addr;
          mem_rw_d   = 1'b0;
          mem_size_d = ld_size;
        end
        if (grant_if || grant_ld || grant_st) begin
          mem_task_d = 1'b1;
          state_d    = S_BUSY;
        end
        // Age tracks how many grants in a row a waiting fetch has lost.
        if (grant_if || !if_req) begin
          age_d = '0;
        end else if ((grant_st || grant_ld) && (age_q != AGE_MAX)) begin
          age_d = age_q + AGE_W'(1);
        end
      end

      S_BUSY: begin
        if (squash_now) squash_d = 1'b1;
        if (mem_task_done) begin
          mem_task_d = 1'b0;
          state_d    = S_RESP;
          case (winner_q)
            W_IF:    begin if_data_d = mem_rdata; if_done_d = ~suppress_done; end
            W_LD:    begin ld_data_d = mem_rdata; ld_done_d = ~suppress_done; end
            default: st_done_d = 1'b1;
          endcase
        end
      end

      S_RESP: begin
        squash_d = 1'b0;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_if_q, stat_if_d;
  logic [31:0] stat_ld_q, stat_ld_d;
  logic [31:0] stat_st_q, stat_st_d;
  logic [31:0] stat_sq_q, stat_sq_d;

  always_comb begin
    stat_if_d = stat_if_q + {31'd0, grant_if};
    stat_ld_d = stat_ld_q + {31'd0, grant_ld};
    stat_st_d = stat_st_q + {31'd0, grant_st};
    stat_sq_d = stat_sq_q + {31'd0, suppress_done};
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      stat_if_q <= '0;
      stat_ld_q <= '0;
      stat_st_q <= '0;
      stat_sq_q <= '0;
    end else if (rdy_in) begin
      stat_if_q <= stat_if_d;
      stat_ld_q <= stat_ld_d;
      stat_st_q <= stat_st_d;
      stat_sq_q <= stat_sq_d;
    end
  end

  assign stat_if_cnt     = stat_if_q;
  assign stat_ld_cnt     = stat_ld_q;
  assign stat_st_cnt     = stat_st_q;
  assign stat_squash_cnt = stat_sq_q;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      winner_q    <= W_IF;
      mem_task_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_rw_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      ld_done_q   <= 1'b0;
      st_done_q   <= 1'b0;
      if_data_q   <= '0;
      ld_data_q   <= '0;
      age_q       <= '0;
      squash_q    <= 1'b0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      mem_task_q  <= mem_task_d;
      mem_addr_q  <= mem_addr_d;
      mem_rw_q    <= mem_rw_d;
      mem_size_q  <= mem_size_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      ld_done_q   <= ld_done_d;
      st_done_q   <= st_done_d;
      if_data_q   <= if_data_d;
      ld_data_q   <= ld_data_d;
      age_q       <= age_d;
      squash_q    <= squash_d;
    end
  end

  assign mem_task  = mem_task_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rw    = mem_rw_q;
  assign mem_size  = mem_size_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign ld_done   = ld_done_q;
  assign st_done   = st_done_q;
  assign if_data   = if_data_q;
  assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: scoreboard of expected tasks, inline adapter model.
module tb_mem_req_arbiter;

  localparam int K_IF = 0;
  localparam int K_LD = 1;
  localparam int K_ST = 2;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_pipline;
  logic        if_req, ld_req, st_req;
  logic [31:0] if_addr, ld_addr, st_addr, st_data;
  logic [1:0]  ld_size, st_size;
  logic        if_done, ld_done, st_done;
  logic [31:0] if_data, ld_data;
  logic        mem_task, mem_rw;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_task_done;
  logic [31:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_if_cnt, stat_ld_cnt, stat_st_cnt, stat_squash_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        rw;
    logic [1:0]  size;
    logic [31:0] wdata;
  } exp_t;
  exp_t sb[$];

  always #5 clk_in = ~clk_in;

  mem_req_arbiter #(.AGE_LIMIT(4), .AGE_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_size(st_size), .st_data(st_data), .st_done(st_done),
    .mem_task(mem_task), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_task_done(mem_task_done), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .stat_if_cnt(stat_if_cnt), .stat_ld_cnt(stat_ld_cnt), .stat_st_cnt(stat_st_cnt),
    .stat_squash_cnt(stat_squash_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] addr, input logic rw,
                      input logic [1:0] size, input logic [31:0] wdata);
    exp_t e;
    e.kind = kind; e.addr = addr; e.rw = rw; e.size = size; e.wdata = wdata;
    sb.push_back(e);
  endtask

  function automatic logic done_of(input int kind);
    case (kind)
      K_IF:    return if_done;
      K_LD:    return ld_done;
      default: return st_done;
    endcase
  endfunction

  // Waits for the next task, checks it against the scoreboard, plays the adapter
  // and checks the completion pulse of the expected requester.
  task automatic serve(input logic [31:0] rdata, input int lat, input bit exp_done,
                       input bit flush_busy, input bit freeze, input bit drop);
    exp_t e;
    int   n;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    n = 0;
    while (mem_task !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("task_start", {31'd0, mem_task}, 32'd1);
    if (mem_task !== 1'b1) return;
    check("task_addr", mem_addr, e.addr);
    check("task_rw", {31'd0, mem_rw}, {31'd0, e.rw});
    check("task_size", {30'd0, mem_size}, {30'd0, e.size});
    if (e.rw) check("task_wdata", mem_wdata, e.wdata);
    if (freeze) begin
      rdy_in = 1'b0;
      mem_task_done = 1'b1;
      mem_rdata = ~rdata;
      for (int i = 0; i < 3; i++) begin
        tick();
        check("frozen_task", {31'd0, mem_task}, 32'd1);
        check("frozen_addr", mem_addr, e.addr);
        check("frozen_done", {29'd0, if_done, ld_done, st_done}, 32'd0);
      end
      mem_task_done = 1'b0;
      rdy_in = 1'b1;
    end
    for (int i = 1; i < lat; i++) begin
      if (flush_busy && i == 1) flush_pipline = 1'b1;
      tick();
      flush_pipline = 1'b0;
    end
    mem_task_done = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_task_done = 1'b0;
    check("resp_task_low", {31'd0, mem_task}, 32'd0);
    check("resp_done", {31'd0, done_of(e.kind)}, {31'd0, exp_done});
    check("resp_other_done", {29'd0, if_done, ld_done, st_done} & ~(32'd1 << (2 - e.kind)), 32'd0);
    if (exp_done && e.kind == K_IF) check("if_data", if_data, rdata);
    if (exp_done && e.kind == K_LD) check("ld_data", ld_data, rdata);
    $display("task kind=%0d addr=0x%08h rw=%0d size=%0d done=%0d", e.kind, e.addr, e.rw, e.size,
             done_of(e.kind));
    if (drop) begin
      case (e.kind)
        K_IF:    if_req = 1'b0;
        K_LD:    ld_req = 1'b0;
        default: st_req = 1'b0;
      endcase
    end
    tick();
    check("done_one_cycle", {29'd0, if_done, ld_done, st_done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush_pipline = 1'b0;
    if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    if_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0; ld_size = '0; st_size = '0;
    mem_task_done = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    check("rst_task", {31'd0, mem_task}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rw_size", {29'd0, mem_rw, mem_size}, 32'd0);
    check("rst_dones", {29'd0, if_done, ld_done, st_done}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    rst_in = 1'b1;
    tick();

    // Single fetch
    if_addr = 32'h0000_1000; if_req = 1'b1;
    push(K_IF, 32'h1000, 1'b0, 2'b10, 32'd0);
    tick();
    check("t1_grant_latency", {31'd0, mem_task}, 32'd1);
    serve(32'h0051_3093, 5, 1'b1, 1'b0, 1'b0, 1'b1);

    // Simultaneous requests: store, load, fetch
    st_addr = 32'h20; st_data = 32'hDEAD_BEEF; st_size = 2'b10;
    ld_addr = 32'h24; ld_size = 2'b01; if_addr = 32'h1004;
    st_req = 1'b1; ld_req = 1'b1; if_req = 1'b1;
    push(K_ST, 32'h20, 1'b1, 2'b10, 32'hDEAD_BEEF);
    push(K_LD, 32'h24, 1'b0, 2'b01, 32'd0);
    push(K_IF, 32'h1004, 1'b0, 2'b10, 32'd0);
    serve(32'h0, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    serve(32'h0000_1234, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    serve(32'h0000_0013, 4, 1'b1, 1'b0, 1'b0, 1'b1);

    // Starvation: fetch wins after 4 consecutive load grants
    if_addr = 32'h1100; if_req = 1'b1; ld_req = 1'b1; ld_size = 2'b10;
    for (int k = 0; k < 4; k++) begin
      ld_addr = 32'h100 + 32'(4 * k);
      push(K_LD, ld_addr, 1'b0, 2'b10, 32'd0);
      serve(32'hA000_0000 + 32'(k), 2, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    ld_addr = 32'h200;
    push(K_IF, 32'h1100, 1'b0, 2'b10, 32'd0);
    serve(32'h0000_0093, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    push(K_LD, 32'h200, 1'b0, 2'b10, 32'd0);
    serve(32'hB000_0000, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    // Age is back to 0: load beats a simultaneous fetch again
    if_addr = 32'h1020; ld_addr = 32'h60; if_req = 1'b1; ld_req = 1'b1;
    push(K_LD, 32'h60, 1'b0, 2'b10, 32'd0);
    push(K_IF, 32'h1020, 1'b0, 2'b10, 32'd0);
    serve(32'hC000_0001, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    serve(32'hC000_0002, 2, 1'b1, 1'b0, 1'b0, 1'b1);

    // Flush during a load squashes its done; next grant is normal
    ld_addr = 32'h30; ld_size = 2'b10; ld_req = 1'b1;
    push(K_LD, 32'h30, 1'b0, 2'b10, 32'd0);
    serve(32'h0000_00FF, 4, 1'b0, 1'b1, 1'b0, 1'b1);
    if_addr = 32'h1008; if_req = 1'b1;
    push(K_IF, 32'h1008, 1'b0, 2'b10, 32'd0);
    serve(32'h0000_0011, 2, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef MEM_ARB_STATS_EN
    check("stat_squash_cnt", stat_squash_cnt, 32'd1);
`endif

    // Flush during a store does not suppress st_done
    st_addr = 32'h40; st_data = 32'h1234_5678; st_size = 2'b00; st_req = 1'b1;
    push(K_ST, 32'h40, 1'b1, 2'b00, 32'h1234_5678);
    serve(32'h0, 3, 1'b1, 1'b1, 1'b0, 1'b1);

    // Flush in IDLE: store still granted, fetch held off
    if_addr = 32'h100C; st_addr = 32'h44; st_data = 32'h0BAD_F00D; st_size = 2'b01;
    if_req = 1'b1; st_req = 1'b1; flush_pipline = 1'b1;
    push(K_ST, 32'h44, 1'b1, 2'b01, 32'h0BAD_F00D);
    push(K_IF, 32'h100C, 1'b0, 2'b10, 32'd0);
    tick();
    flush_pipline = 1'b0;
    check("idle_flush_store_rw", {31'd0, mem_rw}, 32'd1);
    serve(32'h0, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    serve(32'h0000_0033, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    if_addr = 32'h1010; if_req = 1'b1; flush_pipline = 1'b1;
    tick();
    flush_pipline = 1'b0;
    check("idle_flush_no_fetch", {31'd0, mem_task}, 32'd0);
    push(K_IF, 32'h1010, 1'b0, 2'b10, 32'd0);
    serve(32'h0000_0037, 2, 1'b1, 1'b0, 1'b0, 1'b1);

    // Stray adapter completion in IDLE is ignored
    mem_task_done = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_task_done = 1'b0;
    check("stray_done_task", {31'd0, mem_task}, 32'd0);
    tick();
    check("stray_done_pulses", {29'd0, if_done, ld_done, st_done}, 32'd0);

    // rdy_in low for 3 cycles mid-BUSY freezes everything
    ld_addr = 32'h50; ld_size = 2'b10; ld_req = 1'b1;
    push(K_LD, 32'h50, 1'b0, 2'b10, 32'd0);
    serve(32'hCAFE_F00D, 3, 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset mid-BUSY abandons the task
    if_addr = 32'h4000; if_req = 1'b1;
    tick();
    check("rst_mid_task_started", {31'd0, mem_task}, 32'd1);
    tick();
    rst_in = 1'b0; if_req = 1'b0;
    tick();
    rst_in = 1'b1;
    check("rst_mid_task_low", {31'd0, mem_task}, 32'd0);
    check("rst_mid_addr", mem_addr, 32'd0);
    check("rst_mid_dones", {29'd0, if_done, ld_done, st_done}, 32'd0);
    repeat (2) tick();
    check("rst_mid_idle", {29'd0, mem_task, if_done, ld_done}, 32'd0);
    if_addr = 32'h4004; if_req = 1'b1;
    push(K_IF, 32'h4004, 1'b0, 2'b10, 32'd0);
    serve(32'h0000_0073, 3, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
